// File: rtl/sha256_msg_padder_if.sv
// Byte-in / chunk-out bus of the SHA-256 message padder.
// Handshake: a beat transfers on a rising clk edge where valid && ready; the sender holds data stable while valid && !ready.
interface sha256_msg_padder_if;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [511:0] out_chunk;
    logic         out_valid;
    logic         out_last;
    logic         out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_chunk, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_chunk, out_valid, out_last
    );
endinterface

// File: rtl/sha256_msg_padder.sv
// FIPS 180-4 message padder: byte stream in, 512-bit chunks out, final chunk flagged.
// Optional statistics (msg_count, busy) are built when SHA256_PADDER_STATS_EN is defined.
module sha256_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    sha256_msg_padder_if.slave   bus,
`ifdef SHA256_PADDER_STATS_EN
    output logic [15:0]          msg_count,
    output logic                 busy,
`endif
    output logic [2:0]           dbg_state_o
);

    typedef enum logic [2:0] {
        FILL         = 3'd0,
        EMIT_DATA    = 3'd1,
        PAD          = 3'd2,
        EMIT_PENDING = 3'd3,
        EMIT_FINAL   = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [511:0]       buf_q, buf_d;
    logic [6:0]         count_q, count_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               pad_done_q, pad_done_d;
    logic               in_xfer;
    logic               out_xfer;
    logic [8:0]         slot;

    assign bus.in_ready  = (state_q == FILL) && !reset;
    assign bus.out_valid = state_q inside {EMIT_DATA, EMIT_PENDING, EMIT_FINAL};
    assign bus.out_last  = (state_q == EMIT_FINAL);
    assign bus.out_chunk = buf_q;
    assign dbg_state_o   = state_q;

    assign in_xfer  = bus.in_valid && bus.in_ready;
    assign out_xfer = bus.out_valid && bus.out_ready;
    // Byte n lives at bits [511-8n -: 8], i.e. starting at bit 8*(63-n).
    assign slot = {~count_q[5:0], 3'b000};

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        count_d    = count_q;
        len_d      = len_q;
        pad_done_d = pad_done_q;
        unique case (state_q)
            FILL: begin
                if (in_xfer) begin
                    buf_d[slot +: 8] = bus.in_data;
                    len_d            = len_q + LEN_W'(8);
                    if (bus.in_last) begin
                        count_d = count_q + 7'd1;
                        state_d = PAD;
                    end else if (count_q == 7'd63) begin
                        state_d = EMIT_DATA;
                    end else begin
                        count_d = count_q + 7'd1;
                    end
                end
            end
            EMIT_DATA: begin
                if (out_xfer) begin
                    buf_d   = '0;
                    count_d = '0;
                    state_d = FILL;
                end
            end
            PAD: begin
                // Bytes past the message are already zero: the buffer is cleared after every emit.
                if (count_q <= 7'd55) begin
                    buf_d[slot +: 8] = 8'h80;
                    buf_d[63:0]      = 64'(len_q);
                    state_d          = EMIT_FINAL;
                end else if (!count_q[6]) begin
                    buf_d[slot +: 8] = 8'h80;
                    pad_done_d       = 1'b1;
                    state_d          = EMIT_PENDING;
                end else begin
                    pad_done_d = 1'b0;
                    state_d    = EMIT_PENDING;
                end
            end
            EMIT_PENDING: begin
                if (out_xfer) begin
                    buf_d       = '0;
                    buf_d[63:0] = 64'(len_q);
                    if (!pad_done_q) buf_d[511:504] = 8'h80;
                    state_d     = EMIT_FINAL;
                end
            end
            EMIT_FINAL: begin
                if (out_xfer) begin
                    buf_d      = '0;
                    count_d    = '0;
                    len_d      = '0;
                    pad_done_d = 1'b0;
                    state_d    = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FILL;
            buf_q      <= '0;
            count_q    <= '0;
            len_q      <= '0;
            pad_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            count_q    <= count_d;
            len_q      <= len_d;
            pad_done_q <= pad_done_d;
        end
    end

`ifdef SHA256_PADDER_STATS_EN
    logic [15:0] msg_count_q, msg_count_d;

    always_comb begin
        msg_count_d = msg_count_q;
        if (state_q == EMIT_FINAL && out_xfer) msg_count_d = msg_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) msg_count_q <= '0;
        else       msg_count_q <= msg_count_d;
    end

    assign msg_count = msg_count_q;
    assign busy      = (state_q != FILL) || (count_q != 7'd0);
`endif

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: padding of short, boundary and full-block messages,
// backpressure, mid-message reset and back-to-back messages.
module tb_sha256_msg_padder;
    logic clk = 1'b0;
    logic reset;
    logic [2:0] dbg_state;
`ifdef SHA256_PADDER_STATS_EN
    logic [15:0] msg_count;
    logic        busy;
`endif
    int checks = 0;
    int errors = 0;
    logic [511:0] exp_q[$];

    always #5 clk = ~clk;

    sha256_msg_padder_if bus ();

    sha256_msg_padder #(.LEN_W(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
`ifdef SHA256_PADDER_STATS_EN
        .msg_count   (msg_count),
        .busy        (busy),
`endif
        .dbg_state_o (dbg_state)
    );

    // Entered and left on a falling edge; the byte transfers on the rising edge in between.
    task automatic send_byte(input logic [7:0] d, input logic last);
        int guard;
        guard = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        while (bus.in_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout: in_ready=%b required 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_msg(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) send_byte(v, i == n - 1);
    endtask

    task automatic get_chunk(output logic [511:0] chunk, output logic last, output logic ok);
        int guard;
        guard = 0;
        bus.out_ready = 1'b1;
        while (bus.out_valid !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        ok    = (guard < 100);
        chunk = bus.out_chunk;
        last  = bus.out_last;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.in_data = 8'h00; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
        checks++; if (bus.out_chunk !== 512'h0) begin errors++; $display("FAIL reset_out_chunk: got %h want 0", bus.out_chunk); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); end
`ifdef SHA256_PADDER_STATS_EN
        checks++; if (msg_count !== 16'd0) begin errors++; $display("FAIL reset_msg_count: got %0d want 0", msg_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
`endif
    endtask

    task automatic test_abc;
        logic [511:0] chunk;
        logic last, ok;
        bus.in_last = 1'b1;
        repeat (2) @(negedge clk);
        bus.in_last = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL abc_last_without_valid: out_valid=%b want 0", bus.out_valid); end
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL abc_pad_cycle_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL abc_pad_cycle_ready: got %b want 0", bus.in_ready); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL abc_latency: out_valid=%b want 1 two cycles after last byte", bus.out_valid); end
        get_chunk(chunk, last, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL abc_timeout: no chunk within bound"); end
        checks++; if (chunk !== {32'h61626380, 416'h0, 64'h18}) begin errors++; $display("FAIL abc_chunk: got %h want %h", chunk, {32'h61626380, 416'h0, 64'h18}); end
        checks++; if (last !== 1'b1) begin errors++; $display("FAIL abc_last: got %b want 1", last); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL abc_ready_after_final: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_55_bytes;
        logic [511:0] chunk;
        logic last, ok;
        send_msg(8'h00, 55);
        get_chunk(chunk, last, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL len55_timeout: no chunk within bound"); end
        checks++; if (chunk !== {440'h0, 8'h80, 64'h1B8}) begin errors++; $display("FAIL len55_chunk: got %h want %h", chunk, {440'h0, 8'h80, 64'h1B8}); end
        checks++; if (last !== 1'b1) begin errors++; $display("FAIL len55_last: got %b want 1", last); end
    endtask

    task automatic test_56_bytes;
        logic [511:0] chunk, exp;
        logic last, ok;
        exp_q.push_back({{56{8'hFF}}, 8'h80, 56'h0});
        exp_q.push_back({448'h0, 64'h1C0});
        send_msg(8'hFF, 56);
        for (int k = 0; k < 2; k++) begin
            get_chunk(chunk, last, ok);
            exp = exp_q.pop_front();
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL len56_timeout_%0d: no chunk within bound", k); end
            checks++; if (chunk !== exp) begin errors++; $display("FAIL len56_chunk_%0d: got %h want %h", k, chunk, exp); end
            checks++; if (last !== (k == 1)) begin errors++; $display("FAIL len56_last_%0d: got %b want %b", k, last, k == 1); end
        end
    endtask

    task automatic test_64_bytes;
        logic [511:0] chunk, exp;
        logic last, ok;
        exp_q.push_back({64{8'h5A}});
        exp_q.push_back({32'h80000000, 416'h0, 64'h200});
        send_msg(8'h5A, 64);
        for (int k = 0; k < 2; k++) begin
            get_chunk(chunk, last, ok);
            exp = exp_q.pop_front();
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL len64_timeout_%0d: no chunk within bound", k); end
            checks++; if (chunk !== exp) begin errors++; $display("FAIL len64_chunk_%0d: got %h want %h", k, chunk, exp); end
            checks++; if (last !== (k == 1)) begin errors++; $display("FAIL len64_last_%0d: got %b want %b", k, last, k == 1); end
        end
    endtask

    task automatic test_backpressure;
        logic [511:0] held;
        logic held_last;
        int guard;
        guard = 0;
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
        while (bus.out_valid !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++; if (guard >= 20) begin errors++; $display("FAIL bp_timeout: out_valid=%b want 1", bus.out_valid); end
        held      = bus.out_chunk;
        held_last = bus.out_last;
        checks++; if (held !== {32'h61626380, 416'h0, 64'h18}) begin errors++; $display("FAIL bp_chunk: got %h want %h", held, {32'h61626380, 416'h0, 64'h18}); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_%0d: got %b want 1", i, bus.out_valid); end
            checks++; if (bus.out_chunk !== held || bus.out_last !== held_last) begin errors++; $display("FAIL bp_stable_%0d: chunk %h last %b want %h last %b", i, bus.out_chunk, bus.out_last, held, held_last); end
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_%0d: got %b want 0", i, bus.in_ready); end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_transfer: out_valid=%b want 0 after one ready cycle", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_reset_mid;
        logic [511:0] chunk;
        logic last, ok;
        for (int i = 0; i < 20; i++) send_byte(8'h33, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid_%0d: got %b want 0", i, bus.out_valid); end
        end
`ifdef SHA256_PADDER_STATS_EN
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
`endif
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
        get_chunk(chunk, last, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rst_mid_timeout: no chunk within bound"); end
        checks++; if (chunk !== {32'h61626380, 416'h0, 64'h18}) begin errors++; $display("FAIL rst_mid_chunk: got %h want %h", chunk, {32'h61626380, 416'h0, 64'h18}); end
        checks++; if (last !== 1'b1) begin errors++; $display("FAIL rst_mid_last: got %b want 1", last); end
`ifdef SHA256_PADDER_STATS_EN
        checks++; if (msg_count !== 16'd1) begin errors++; $display("FAIL rst_mid_msg_count: got %0d want 1", msg_count); end
`endif
    endtask

    task automatic test_back_to_back;
        logic [511:0] chunk;
        logic last, ok;
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
        get_chunk(chunk, last, ok);
        checks++; if (ok !== 1'b1 || chunk !== {32'h61626380, 416'h0, 64'h18}) begin errors++; $display("FAIL b2b_first: ok %b chunk %h want %h", ok, chunk, {32'h61626380, 416'h0, 64'h18}); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", bus.in_ready); end
        send_byte(8'h01, 1'b1);
        get_chunk(chunk, last, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_timeout: no chunk within bound"); end
        checks++; if (chunk !== {16'h0180, 432'h0, 64'h8}) begin errors++; $display("FAIL b2b_second: got %h want %h", chunk, {16'h0180, 432'h0, 64'h8}); end
        checks++; if (last !== 1'b1) begin errors++; $display("FAIL b2b_last: got %b want 1", last); end
`ifdef SHA256_PADDER_STATS_EN
        checks++; if (msg_count !== 16'd3) begin errors++; $display("FAIL b2b_msg_count: got %0d want 3", msg_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_abc();
        test_55_bytes();
        test_56_bytes();
        test_64_bytes();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
